// File: rtl/bulk_read_arbiter_if.sv
// Bulk (cache-line) read/write port shared by cache masters and memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. Once the master raises req_valid it holds it and
// every req_* field stable until that edge. A response is a single-cycle
// resp_valid pulse carrying a whole line in resp_rdata; it cannot be stalled.
interface bulk_read_interface #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 16
);
  localparam int STRB_W = DATA_W / 8;

  logic                                req_valid;
  logic                                req_ready;
  logic [ADDR_W-1:0]                   req_addr;
  logic                                req_write;
  logic [LINE_SIZE-1:0][DATA_W-1:0]    req_wdata;
  logic [LINE_SIZE-1:0][STRB_W-1:0]    req_wstrb;
  logic                                dumping_cache;
  logic                                resp_valid;
  logic [LINE_SIZE-1:0][DATA_W-1:0]    resp_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bulk_read_arbiter.sv
// Arbitrates NUM_REQ cache masters onto one bulk memory port. One transaction
// in flight; cache-dump writebacks win over normal traffic, which is served
// round-robin. The response is steered back to the owning master only.
module bulk_read_arbiter #(
  parameter int  NUM_REQ   = 2,
  parameter int  DATA_W    = 64,
  parameter int  ADDR_W    = 64,
  parameter int  LINE_SIZE = 16,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bulk_read_interface.slave  req_if [NUM_REQ],
  bulk_read_interface.master mem_if,
  output logic               busy,
  output logic [IDX_W-1:0]   owner,
  output logic [1:0]         state_dbg
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Flattened view of the upstream ports so they can be indexed dynamically.
  logic [NUM_REQ-1:0]               req_valid_v;
  logic [NUM_REQ-1:0]               dump_v;
  logic [NUM_REQ-1:0]               write_v;
  logic [NUM_REQ-1:0]               ready_v;
  logic [NUM_REQ-1:0]               resp_valid_v;
  logic [ADDR_W-1:0]                addr_v  [NUM_REQ];
  logic [LINE_SIZE-1:0][DATA_W-1:0] wdata_v [NUM_REQ];
  logic [LINE_SIZE-1:0][STRB_W-1:0] wstrb_v [NUM_REQ];

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                 owner_q, owner_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic                             write_q, write_d;
  logic [LINE_SIZE-1:0][DATA_W-1:0] wdata_q, wdata_d;
  logic [LINE_SIZE-1:0][STRB_W-1:0] wstrb_q, wstrb_d;

  logic                             win_valid;
  logic [IDX_W-1:0]                 win_idx;

  // (base + off) modulo NUM_REQ, valid for NUM_REQ that is not a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign req_valid_v[g]       = req_if[g].req_valid;
    assign dump_v[g]            = req_if[g].dumping_cache;
    assign write_v[g]           = req_if[g].req_write;
    assign addr_v[g]            = req_if[g].req_addr;
    assign wdata_v[g]           = req_if[g].req_wdata;
    assign wstrb_v[g]           = req_if[g].req_wstrb;
    assign req_if[g].req_ready  = ready_v[g];
    assign req_if[g].resp_valid = resp_valid_v[g];
    // Data is broadcast; only the owner sees resp_valid.
    assign req_if[g].resp_rdata = mem_if.resp_rdata;
  end

  assign mem_if.req_valid     = (state_q == S_ISSUE);
  assign mem_if.req_addr      = addr_q;
  assign mem_if.req_write     = write_q;
  assign mem_if.req_wdata     = wdata_q;
  assign mem_if.req_wstrb     = wstrb_q;
  assign mem_if.dumping_cache = |dump_v;

  assign owner     = owner_q;
  assign state_dbg = state_q;

  // Winner pick: lowest-index dump first, else first valid at/after rr_ptr.
  // Loops run high-to-low so the preferred candidate is assigned last.
  always_comb begin
    logic dump_found;
    win_valid  = 1'b0;
    win_idx    = '0;
    dump_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_v[IDX_W'(i)] && dump_v[IDX_W'(i)]) begin
        dump_found = 1'b1;
        win_idx    = IDX_W'(i);
      end
    end
    if (dump_found) begin
      win_valid = 1'b1;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid_v[wrap_add(rr_ptr_q, k)]) begin
          win_valid = 1'b1;
          win_idx   = wrap_add(rr_ptr_q, k);
        end
      end
    end
  end

  // State register and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  // Next state: accept in IDLE, hand off in ISSUE, finish on response in WAIT.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          owner_d  = win_idx;
          addr_d   = addr_v[win_idx];
          write_d  = write_v[win_idx];
          wdata_d  = wdata_v[win_idx];
          wstrb_d  = wstrb_v[win_idx];
          rr_ptr_d = wrap_add(win_idx, 1);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_if.req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_if.resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: grant ready in IDLE, route the response pulse to the owner in WAIT.
  always_comb begin
    ready_v      = '0;
    resp_valid_v = '0;
    busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
    if (state_q == S_IDLE && win_valid) ready_v[win_idx] = 1'b1;
    if (state_q == S_WAIT && mem_if.resp_valid) resp_valid_v[owner_q] = 1'b1;
  end
endmodule

// File: tb/tb_bulk_read_arbiter.sv
// Directed bench for bulk_read_arbiter with two masters and a scripted memory.
module tb_bulk_read_arbiter;
  localparam int NR        = 2;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 64;
  localparam int LINE_SIZE = 4;
  localparam int CW        = LINE_SIZE * DATA_W;
  localparam int SW        = LINE_SIZE * DATA_W / 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Master-side stimulus and observations
  logic              m_valid [NR];
  logic [ADDR_W-1:0] m_addr  [NR];
  logic              m_write [NR];
  logic [CW-1:0]     m_wdata [NR];
  logic [SW-1:0]     m_wstrb [NR];
  logic              m_dump  [NR];
  logic              s_ready      [NR];
  logic              s_resp_valid [NR];
  logic [CW-1:0]     s_resp_rdata [NR];

  // Memory-side stimulus
  logic          mem_ready;
  logic          mem_resp_valid;
  logic [CW-1:0] mem_resp_rdata;

  logic       busy;
  logic [0:0] owner;
  logic [1:0] state_dbg;

  bulk_read_interface #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE)) req_bus [NR] ();
  bulk_read_interface #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE)) mem_bus ();

  for (genvar g = 0; g < NR; g++) begin : g_m
    assign req_bus[g].req_valid     = m_valid[g];
    assign req_bus[g].req_addr      = m_addr[g];
    assign req_bus[g].req_write     = m_write[g];
    assign req_bus[g].req_wdata     = m_wdata[g];
    assign req_bus[g].req_wstrb     = m_wstrb[g];
    assign req_bus[g].dumping_cache = m_dump[g];
    assign s_ready[g]               = req_bus[g].req_ready;
    assign s_resp_valid[g]          = req_bus[g].resp_valid;
    assign s_resp_rdata[g]          = req_bus[g].resp_rdata;
  end

  assign mem_bus.req_ready  = mem_ready;
  assign mem_bus.resp_valid = mem_resp_valid;
  assign mem_bus.resp_rdata = mem_resp_rdata;

  bulk_read_arbiter #(
    .NUM_REQ(NR), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if    (req_bus),
    .mem_if    (mem_bus),
    .busy      (busy),
    .owner     (owner),
    .state_dbg (state_dbg)
  );

  // Scoreboard: expected owner of each response, pushed at grant time
  logic [7:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int txn_cnt  = 0;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] make_line(input int t);
    logic [CW-1:0] l;
    l = '0;
    for (int k = 0; k < LINE_SIZE; k++) l[k*DATA_W +: DATA_W] = {32'(t), 32'(k)};
    return l;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0; m_addr[i] = '0; m_write[i] = 1'b0;
      m_wdata[i] = '0;   m_wstrb[i] = '0; m_dump[i] = 1'b0;
    end
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_state", state_dbg, 0);
    check("rst_ready0", s_ready[0], 0);
    check("rst_ready1", s_ready[1], 0);
    check("rst_mem_valid", mem_bus.req_valid, 0);
    check("rst_mem_write", mem_bus.req_write, 0);
    check("rst_mem_addr", mem_bus.req_addr, 0);
    check("rst_mem_wdata", mem_bus.req_wdata, 0);
    check("rst_mem_wstrb", mem_bus.req_wstrb, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One transaction; caller has driven the masters at the current negedge.
  task automatic run_txn(input int win, input logic [ADDR_W-1:0] addr, input logic wr,
                         input int stall, input bit spur, input bit drop, input int delay);
    logic [CW-1:0] wd;
    logic [SW-1:0] ws;
    logic [CW-1:0] line;
    logic          dump_exp;
    logic [7:0]    obs_own;
    logic [7:0]    e;
    #1;
    check("grant_ready_win", s_ready[win], 1);
    check("grant_ready_other", s_ready[1-win], 0);
    wd = m_wdata[win];
    ws = m_wstrb[win];
    exp_q.push_back(win[7:0]);
    @(negedge clk);
    if (drop) m_valid[win] = 1'b0;
    #1;
    dump_exp = m_dump[0] | m_dump[1];
    check("issue_valid", mem_bus.req_valid, 1);
    check("issue_addr", mem_bus.req_addr, addr);
    check("issue_write", mem_bus.req_write, wr);
    check("issue_wdata", mem_bus.req_wdata, wd);
    check("issue_wstrb", mem_bus.req_wstrb, ws);
    check("issue_dump", mem_bus.dumping_cache, dump_exp);
    check("issue_busy", busy, 1);
    check("issue_owner", owner, win[0]);
    check("issue_ready0", s_ready[0], 0);
    check("issue_ready1", s_ready[1], 0);
    for (int s = 0; s < stall; s++) begin
      if (spur && s == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = make_line(99);
        #1;
        check("spur_issue_resp0", s_resp_valid[0], 0);
        check("spur_issue_resp1", s_resp_valid[1], 0);
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      check("stall_valid", mem_bus.req_valid, 1);
      check("stall_addr", mem_bus.req_addr, addr);
      check("stall_wdata", mem_bus.req_wdata, wd);
      check("stall_state", state_dbg, 1);
      check("stall_ready0", s_ready[0], 0);
      check("stall_ready1", s_ready[1], 0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("wait_valid", mem_bus.req_valid, 0);
    check("wait_state", state_dbg, 2);
    repeat (delay - 1) @(negedge clk);
    line = make_line(txn_cnt);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = line;
    #1;
    check("resp_valid_win", s_resp_valid[win], 1);
    check("resp_valid_other", s_resp_valid[1-win], 0);
    check("resp_rdata", s_resp_rdata[win], line);
    obs_own = s_resp_valid[0] ? 8'd0 : (s_resp_valid[1] ? 8'd1 : 8'hff);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb_owner", obs_own, e);
    end
    txn_cnt++;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("done_resp0", s_resp_valid[0], 0);
    check("done_resp1", s_resp_valid[1], 0);
    check("done_busy", busy, 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();

    // Single read from master 0, response three cycles after req_ready.
    m_valid[0] = 1'b1; m_addr[0] = 64'h1000;
    run_txn(0, 64'h1000, 1'b0, 0, 1'b0, 1'b1, 3);

    // Round-robin with both masters continuously valid from reset.
    apply_reset();
    m_valid[0] = 1'b1; m_addr[0] = 64'h2000;
    m_valid[1] = 1'b1; m_addr[1] = 64'h3000;
    run_txn(0, 64'h2000, 1'b0, 0, 1'b0, 1'b0, 2);
    run_txn(1, 64'h3000, 1'b0, 0, 1'b0, 1'b0, 1);
    run_txn(0, 64'h2000, 1'b0, 0, 1'b0, 1'b1, 2);
    run_txn(1, 64'h3000, 1'b0, 0, 1'b0, 1'b1, 1);

    // Dump priority: rr_ptr is 0, yet the dumping master 1 wins.
    m_valid[0] = 1'b1; m_addr[0] = 64'h4000; m_write[0] = 1'b0;
    m_valid[1] = 1'b1; m_addr[1] = 64'h5000; m_write[1] = 1'b1;
    m_wdata[1] = make_line(3); m_wstrb[1] = '1; m_dump[1] = 1'b1;
    run_txn(1, 64'h5000, 1'b1, 0, 1'b0, 1'b1, 2);
    m_dump[1] = 1'b0; m_write[1] = 1'b0;
    run_txn(0, 64'h4000, 1'b0, 0, 1'b0, 1'b1, 2);

    // Spurious response in IDLE: ignored, no state change.
    mem_resp_valid = 1'b1; mem_resp_rdata = make_line(55);
    #1;
    check("spur_idle_resp0", s_resp_valid[0], 0);
    check("spur_idle_resp1", s_resp_valid[1], 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("spur_idle_state", state_dbg, 0);
    check("spur_idle_busy", busy, 0);

    // Backpressure for 5 cycles with a spurious pulse in ISSUE; master 0
    // waits meanwhile and is served next.
    m_valid[1] = 1'b1; m_addr[1] = 64'h6000; m_wdata[1] = make_line(5); m_wstrb[1] = '1;
    m_valid[0] = 1'b1; m_addr[0] = 64'h6800; m_wdata[0] = make_line(6);
    run_txn(1, 64'h6000, 1'b0, 5, 1'b1, 1'b1, 2);
    run_txn(0, 64'h6800, 1'b0, 0, 1'b0, 1'b1, 1);

    // Reset while in WAIT; a late memory response must be ignored.
    @(negedge clk);
    m_valid[0] = 1'b1; m_addr[0] = 64'h7000;
    #1;
    check("rw_grant0", s_ready[0], 1);
    @(negedge clk);
    m_valid[0] = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("rw_in_wait", state_dbg, 2);
    check("rw_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rw_busy_reset", busy, 0);
    check("rw_state_reset", state_dbg, 0);
    check("rw_mem_valid_reset", mem_bus.req_valid, 0);
    check("rw_mem_addr_reset", mem_bus.req_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = make_line(77);
    #1;
    check("rw_late_resp0", s_resp_valid[0], 0);
    check("rw_late_resp1", s_resp_valid[1], 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("rw_busy_after", busy, 0);
    check("rw_state_after", state_dbg, 0);
    // rr_ptr restarted at 0, so master 0 wins over master 1.
    m_valid[0] = 1'b1; m_addr[0] = 64'h8000;
    m_valid[1] = 1'b1; m_addr[1] = 64'h8800;
    run_txn(0, 64'h8000, 1'b0, 0, 1'b0, 1'b1, 2);
    run_txn(1, 64'h8800, 1'b0, 0, 1'b0, 1'b1, 2);

    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/bulk_read_arbiter.md
Name: bulk_read_arbiter

Overview:
- Shares one downstream bulk (cache-line) memory port between NUM_REQ cache masters, e.g. I-cache and D-cache.
- Each master sees a slave-side bulk_read_interface. The single memory port is a master-side bulk_read_interface.
- Only one transaction is in flight at a time. Normal requests are granted round-robin; cache-dump writebacks are granted first.
- The winning request is latched, issued downstream, and held until the memory response, which is routed back only to the owning master.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- DATA_W, 64, word width; passed to all interfaces.
- ADDR_W, 64, address width.
- LINE_SIZE, 16, words per line.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_if  interface array [NUM_REQ]  bulk_read_interface.slave  one upstream port per requester.
- mem_if  interface  bulk_read_interface.master  shared downstream memory port.
- busy  output  1  high while a transaction is owned (ISSUE or WAIT).
- owner  output  $clog2(NUM_REQ) (min 1)  index of the current or last granted requester.

Behaviour:
- Reset values:
  - FSM state IDLE; rr_ptr=0; owner=0; busy=0.
  - All req_if[i].req_ready=0 and req_if[i].resp_valid=0.
  - mem_if.req_valid=0, mem_if.req_write=0, mem_if.req_addr=0.
  - Latched wdata/wstrb cleared to 0.
- FSM states:
  - IDLE: choose a winner, combinationally from current-cycle req_valid:
    - If any requester has req_valid & dumping_cache, the lowest such index wins.
    - Otherwise, the first valid requester at or after rr_ptr (wrapping modulo NUM_REQ) wins.
  - IDLE grant: req_if[win].req_ready=1 in the same cycle, all others 0. This is the acceptance cycle.
  - IDLE latching at that edge: addr, write, wdata[], wstrb[], owner=win. Then rr_ptr=(win+1) mod NUM_REQ and go to ISSUE.
  - IDLE with no valid requester: stay in IDLE, all ready=0.
  - ISSUE: mem_if.req_valid=1 with the latched fields, held stable. When mem_if.req_ready=1, go to WAIT.
  - WAIT: mem_if.req_valid=0. On mem_if.resp_valid=1:
    - req_if[owner].resp_valid=1 for exactly that cycle, combinationally.
    - req_if[owner].resp_rdata = mem_if.resp_rdata.
    - Go to IDLE.
- Latency:
  - Accept at cycle N gives mem_if.req_valid high from cycle N+1.
  - Response is forwarded with zero cycles added.
  - The next grant is possible the cycle after the response.
- Non-owner resp_valid is always 0. Non-owner resp_rdata mirrors mem_if.resp_rdata; masters must qualify it with resp_valid.
- busy=1 in ISSUE and WAIT, else 0.
- Requests arriving while not in IDLE are not accepted (ready=0). Masters must hold req_valid per the handshake.
- mem_if.dumping_cache = OR over all req_if[i].dumping_cache, passed through combinationally.
- mem_if.resp_valid in IDLE or ISSUE is spurious and ignored: not forwarded, no state change.
- Simultaneous dump requests from several masters: lowest index wins; rr_ptr still advances past the winner.
- NUM_REQ=1: degenerates to pass-through with one cycle of issue latency; rr_ptr stays 0.
- Reset mid-transaction (any state): immediately return to reset values. Any later response from memory lands in IDLE and is ignored.
- The write response uses the same path: resp_valid is forwarded, and rdata content is don't-care.

Test Plan:
- Single read: req 0 valid, addr 0x1000 → ready0 high the same cycle; mem req_valid next cycle with addr 0x1000, write=0. Memory responds 3 cycles after req_ready with rdata[k]=k → resp_valid0 one cycle with rdata[k]=k; resp_valid1 stays 0.
- Round-robin fairness: both masters continuously valid for 4 transactions from reset → grant order 0,1,0,1; owner output matches each.
- Dump priority: rr_ptr=0, req0 normal and req1 write with dumping_cache=1 asserted the same cycle → req1 granted first. mem dumping_cache=1, mem req_write=1, wstrb=all-ones forwarded intact.
- Backpressure: mem req_ready held 0 for 5 cycles in ISSUE → req_valid held and addr/wdata stable all 5 cycles; upstream ready stays 0 for both masters.
- Spurious response: mem resp_valid pulsed in IDLE and in ISSUE → no upstream resp_valid, no state change.
- Reset mid-WAIT: rst_n low during WAIT, then a memory response after release → busy=0, no resp_valid forwarded; the next request is granted to req0 (rr_ptr=0).
